demux_resultado: RTL and testbench

DEMUX_RESULTADO -- requirements
Module: demux_resultado

---
 rtl/demux_resultado_if.sv | 62 ++++++
 rtl/demux_resultado.sv | 175 +++++++++++++++++
 tb/tb_demux_resultado.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_resultado_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_resultado_if
// Description : Result bus between the ALU side, the register-file port (D0)
//               and the Otro (DMA/protocol) port of demux_resultado.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_resultado_if #(
  parameter int WIDTH = 32
);

  // ALU result offer
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] Resultado;
  logic             sel_dest;

  // Register-file write port
  logic             D0_we;
  logic [WIDTH-1:0] D0_data;

  // Otro port (valid/ready)
  logic             Otro_valid;
  logic             Otro_ready;
  logic [WIDTH-1:0] Otro_data;

  // Status
  logic             err_timeout;
  logic [1:0]       ocupacion;

  // Environment side: offers results and consumes the Otro port
  modport master (
    output res_valid,
    output Resultado,
    output sel_dest,
    output Otro_ready,
    input  res_ready,
    input  D0_we,
    input  D0_data,
    input  Otro_valid,
    input  Otro_data,
    input  err_timeout,
    input  ocupacion
  );

  // Demultiplexer side
  modport slave (
    input  res_valid,
    input  Resultado,
    input  sel_dest,
    input  Otro_ready,
    output res_ready,
    output D0_we,
    output D0_data,
    output Otro_valid,
    output Otro_data,
    output err_timeout,
    output ocupacion
  );

endinterface
`default_nettype wire

// File: rtl/demux_resultado.sv
`default_nettype none
// ============================================================================
// Module      : demux_resultado
// Description : Routes ALU results, in acceptance order, either to the
//               register-file write port (D0, single-cycle strobe) or to the
//               Otro valid/ready port. A 2-entry FIFO decouples the ALU from
//               Otro back-pressure; a sticky flag reports a long Otro stall.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_resultado #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255   // legal range 1..255
) (
  input  wire              clk,
  input  wire              rst,
  demux_resultado_if.slave io_bus
);

  // --------------------------------------------------------------------------
  // Constants and types
  // --------------------------------------------------------------------------
  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);
  localparam logic [1:0] c_FULL    = 2'd2;
  localparam logic [1:0] c_EMPTY   = 2'd0;

  // VACIO : nothing held
  // ACTIVO: head entry is being delivered
  // ESPERA: head targets Otro and the consumer held it off last cycle
  typedef enum logic [1:0] {
    VACIO  = 2'd0,
    ACTIVO = 2'd1,
    ESPERA = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_data [2];
  logic [1:0]       r_dest;
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic [7:0]       r_stall;
  logic             r_err;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  state_t           w_state_next;
  logic [1:0]       w_count_next;
  logic [7:0]       w_stall_next;
  logic             w_push;
  logic             w_pop;
  logic             w_head_valid;
  logic             w_head_dest;
  logic [WIDTH-1:0] w_head_data;
  logic             w_d0_fire;
  logic             w_otro_pend;
  logic             w_otro_fire;
  logic             w_stalled;

  // Acceptance looks only at the registered count so res_ready never
  // depends on Otro_ready in the same cycle.
  assign w_push       = io_bus.res_valid && (r_count != c_FULL);

  // Head of the FIFO and what it is doing this cycle
  assign w_head_valid = (r_count != c_EMPTY);
  assign w_head_dest  = r_dest[r_rptr];
  assign w_head_data  = r_data[r_rptr];

  // A D0 head always leaves after one cycle; an Otro head needs a handshake.
  assign w_d0_fire    = w_head_valid && !w_head_dest;
  assign w_otro_pend  = w_head_valid &&  w_head_dest;
  assign w_otro_fire  = w_otro_pend  &&  io_bus.Otro_ready;
  assign w_stalled    = w_otro_pend  && !io_bus.Otro_ready;
  assign w_pop        = w_d0_fire || w_otro_fire;

  // Occupancy after this edge; push and pop together leave it unchanged
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Next-state logic for the delivery FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      VACIO: begin
        if (w_push) begin
          w_state_next = ACTIVO;
        end
      end
      ACTIVO, ESPERA: begin
        if (w_count_next == c_EMPTY) begin
          w_state_next = VACIO;
        end else if (w_stalled) begin
          w_state_next = ESPERA;
        end else begin
          w_state_next = ACTIVO;
        end
      end
      default: begin
        w_state_next = VACIO;
      end
    endcase
  end

  // Stall counter: counts consecutive stalled edges, saturating at TIMEOUT;
  // any pop or leaving ESPERA restarts it from zero.
  always_comb begin
    w_stall_next = 8'd0;
    if (w_state_next == ESPERA) begin
      if (r_stall < c_TIMEOUT) begin
        w_stall_next = r_stall + 8'd1;
      end else begin
        w_stall_next = r_stall;
      end
    end
  end

  // Pointers, occupancy, FSM state, stall counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= c_EMPTY;
      r_state <= VACIO;
      r_stall <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= w_count_next;
      r_state <= w_state_next;
      r_stall <= w_stall_next;
      if (w_stall_next == c_TIMEOUT) begin
        r_err <= 1'b1;
      end
    end
  end

  // FIFO storage: {sel_dest, Resultado} written at the write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dest    <= 2'b00;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else if (w_push) begin
      r_dest[r_wptr] <= io_bus.sel_dest;
      r_data[r_wptr] <= io_bus.Resultado;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: data buses read zero whenever their port is idle
  // --------------------------------------------------------------------------
  assign io_bus.res_ready   = (r_count != c_FULL);
  assign io_bus.D0_we       = w_d0_fire;
  assign io_bus.D0_data     = w_d0_fire ? w_head_data : '0;
  assign io_bus.Otro_valid  = w_otro_pend;
  assign io_bus.Otro_data   = w_otro_pend ? w_head_data : '0;
  assign io_bus.err_timeout = r_err;
  assign io_bus.ocupacion   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_demux_resultado.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_resultado
// Description : Directed bench for demux_resultado. Instance A uses the
//               default TIMEOUT, instance B uses TIMEOUT=4 for the stall flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_resultado;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  demux_resultado_if #(.WIDTH(32)) bus_a ();
  demux_resultado_if #(.WIDTH(32)) bus_b ();

  demux_resultado #(.WIDTH(32)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_a)
  );

  demux_resultado #(.WIDTH(32), .TIMEOUT(4)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_b)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full reset-value check of instance A
  task automatic chk_reset_a(input string tag);
    chk({tag, ".res_ready"},  64'(bus_a.res_ready),   64'd1);
    chk({tag, ".D0_we"},      64'(bus_a.D0_we),       64'd0);
    chk({tag, ".D0_data"},    64'(bus_a.D0_data),     64'd0);
    chk({tag, ".Otro_valid"}, 64'(bus_a.Otro_valid),  64'd0);
    chk({tag, ".Otro_data"},  64'(bus_a.Otro_data),   64'd0);
    chk({tag, ".err"},        64'(bus_a.err_timeout), 64'd0);
    chk({tag, ".ocup"},       64'(bus_a.ocupacion),   64'd0);
  endtask

  task automatic push_a(input logic [31:0] data, input logic dest);
    bus_a.res_valid = 1'b1;
    bus_a.Resultado = data;
    bus_a.sel_dest  = dest;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus_a.res_valid = 1'b0; bus_a.Resultado = '0; bus_a.sel_dest = 1'b0; bus_a.Otro_ready = 1'b0;
    bus_b.res_valid = 1'b0; bus_b.Resultado = '0; bus_b.sel_dest = 1'b0; bus_b.Otro_ready = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk_reset_a("rst0");
    chk("rst0.b_err", 64'(bus_b.err_timeout), 64'd0);
    rst = 1'b0;

    // ---------------- single D0 result ----------------
    push_a(32'h0000_00A5, 1'b0);
    tick();
    bus_a.res_valid = 1'b0;
    chk("d0.we",     64'(bus_a.D0_we),      64'd1);
    chk("d0.data",   64'(bus_a.D0_data),    64'h0000_00A5);
    chk("d0.otro_v", 64'(bus_a.Otro_valid), 64'd0);
    chk("d0.ocup1",  64'(bus_a.ocupacion),  64'd1);
    tick();
    chk("d0.we_off", 64'(bus_a.D0_we),      64'd0);
    chk("d0.data0",  64'(bus_a.D0_data),    64'd0);
    chk("d0.ocup0",  64'(bus_a.ocupacion),  64'd0);

    // ---------------- Otro stall, then handshake ----------------
    bus_a.Otro_ready = 1'b0;
    push_a(32'h1234_5678, 1'b1);
    tick();
    bus_a.res_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall.valid", 64'(bus_a.Otro_valid), 64'd1);
      chk("stall.data",  64'(bus_a.Otro_data),  64'h1234_5678);
      chk("stall.d0we",  64'(bus_a.D0_we),      64'd0);
      tick();
    end
    chk("stall.held", 64'(bus_a.Otro_data), 64'h1234_5678);
    bus_a.Otro_ready = 1'b1;
    tick();
    bus_a.Otro_ready = 1'b0;
    chk("stall.done_v", 64'(bus_a.Otro_valid),  64'd0);
    chk("stall.ocup",   64'(bus_a.ocupacion),   64'd0);
    chk("stall.err",    64'(bus_a.err_timeout), 64'd0);

    // ---------------- full FIFO and ordering ----------------
    push_a(32'h1, 1'b1);
    tick();
    push_a(32'h2, 1'b0);
    tick();
    chk("full.ocup",  64'(bus_a.ocupacion), 64'd2);
    chk("full.ready", 64'(bus_a.res_ready), 64'd0);
    chk("full.otro",  64'(bus_a.Otro_data), 64'h1);
    push_a(32'h3, 1'b0);
    tick();
    bus_a.res_valid = 1'b0;
    chk("full.ignored", 64'(bus_a.ocupacion), 64'd2);
    chk("full.d0_blk",  64'(bus_a.D0_we),     64'd0);
    bus_a.Otro_ready = 1'b1;
    chk("full.otro_v",  64'(bus_a.Otro_valid), 64'd1);
    tick();
    bus_a.Otro_ready = 1'b0;
    chk("order.otro_v", 64'(bus_a.Otro_valid), 64'd0);
    chk("order.d0we",   64'(bus_a.D0_we),      64'd1);
    chk("order.d0data", 64'(bus_a.D0_data),    64'h2);
    chk("order.ocup",   64'(bus_a.ocupacion),  64'd1);
    tick();
    chk("order.empty",  64'(bus_a.ocupacion),  64'd0);
    chk("order.no3",    64'(bus_a.D0_we),      64'd0);

    // ---------------- continuous D0 stream ----------------
    for (int i = 1; i <= 8; i++) begin
      push_a(32'(i), 1'b0);
      tick();
      chk("stream.we",   64'(bus_a.D0_we),     64'd1);
      chk("stream.data", 64'(bus_a.D0_data),   64'(i));
      chk("stream.ocup", 64'(bus_a.ocupacion), 64'd1);
    end
    bus_a.res_valid = 1'b0;
    tick();
    chk("stream.end_we",   64'(bus_a.D0_we),     64'd0);
    chk("stream.end_ocup", 64'(bus_a.ocupacion), 64'd0);
    chk("a.err_never",     64'(bus_a.err_timeout), 64'd0);

    // ---------------- timeout on instance B (TIMEOUT=4) ----------------
    bus_b.Otro_ready = 1'b0;
    bus_b.res_valid  = 1'b1;
    bus_b.Resultado  = 32'h0000_BEEF;
    bus_b.sel_dest   = 1'b1;
    tick();
    bus_b.res_valid = 1'b0;
    chk("to.push_err", 64'(bus_b.err_timeout), 64'd0);
    chk("to.valid",    64'(bus_b.Otro_valid),  64'd1);
    tick();
    chk("to.e1", 64'(bus_b.err_timeout), 64'd0);
    tick();
    chk("to.e2", 64'(bus_b.err_timeout), 64'd0);
    tick();
    chk("to.e3", 64'(bus_b.err_timeout), 64'd0);
    tick();
    chk("to.e4", 64'(bus_b.err_timeout), 64'd1);
    tick();
    chk("to.e5", 64'(bus_b.err_timeout), 64'd1);
    chk("to.data_held", 64'(bus_b.Otro_data), 64'h0000_BEEF);
    bus_b.Otro_ready = 1'b1;
    tick();
    bus_b.Otro_ready = 1'b0;
    chk("to.hs_valid", 64'(bus_b.Otro_valid),  64'd0);
    chk("to.hs_err",   64'(bus_b.err_timeout), 64'd1);
    bus_b.res_valid = 1'b1;
    bus_b.Resultado = 32'h55;
    bus_b.sel_dest  = 1'b0;
    tick();
    bus_b.res_valid = 1'b0;
    chk("to.after_we",   64'(bus_b.D0_we),       64'd1);
    chk("to.after_data", 64'(bus_b.D0_data),     64'h55);
    chk("to.after_err",  64'(bus_b.err_timeout), 64'd1);

    // ---------------- asynchronous reset with a full FIFO ----------------
    push_a(32'h0000_DEAD, 1'b1);
    tick();
    push_a(32'h0000_CAFE, 1'b0);
    tick();
    bus_a.res_valid = 1'b0;
    chk("ar.ocup2", 64'(bus_a.ocupacion), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_a("ar");
    chk("ar.b_err", 64'(bus_b.err_timeout), 64'd0);
    tick();
    // First push lands on the first edge after release
    rst = 1'b0;
    bus_a.Otro_ready = 1'b1;
    push_a(32'h77, 1'b0);
    tick();
    bus_a.res_valid = 1'b0;
    chk("first.we",   64'(bus_a.D0_we),   64'd1);
    chk("first.data", 64'(bus_a.D0_data), 64'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar.no_d0",   64'(bus_a.D0_we),      64'd0);
      chk("ar.no_otro", 64'(bus_a.Otro_valid), 64'd0);
      chk("ar.ocup0",   64'(bus_a.ocupacion),  64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
